// File: rtl/dmem_arbiter_pkg.sv
// Shared defaults and port indices for the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int ADDR_W_DEF   = 6;
  localparam int DATA_W_DEF   = 32;
  localparam int LOCK_MAX_DEF = 8;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational two-way picker: lock retention first, then single request, then round-robin.
module dmem_rr_pick
  import dmem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  input  logic lock_ok,
  output logic gnt0,
  output logic gnt1
);

  // Port 1 wins on a live lock, when alone, or when port 0 was served last.
  assign gnt1 = req1 && (lock_ok || !req0 || (last == PORT_CPU));
  assign gnt0 = req0 && !gnt1;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port 64x32 data memory, with bounded lock for port 1.
// Optional conflict counter built only when DMEM_ARB_PERF_EN is defined.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              lock1,
  output logic              MemoryRead,
  output logic              MemoryWrite,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  input  logic [DATA_W-1:0] ReadData,
  output logic [31:0]       conflict_cnt
);

  localparam logic [7:0] LOCK_CAP = 8'(LOCK_MAX);

  logic       last;
  logic       lock_act;
  logic [7:0] lock_cnt;
  logic       lock_ok;
  logic       pick0;
  logic       pick1;
  logic       rv0;
  logic       rv1;

  assign lock_ok = lock_act && lock1 && (lock_cnt < LOCK_CAP);

  // Requests are masked during reset so no grant or memory enable can escape.
  dmem_rr_pick u_pick (
    .req0    (req0 && !Reset),
    .req1    (req1 && !Reset),
    .last    (last),
    .lock_ok (lock_ok),
    .gnt0    (pick0),
    .gnt1    (pick1)
  );

  assign gnt0 = pick0;
  assign gnt1 = pick1;

  always_comb begin
    MemoryRead  = 1'b0;
    MemoryWrite = 1'b0;
    Address     = '0;
    WriteData   = '0;
    if (pick0) begin
      MemoryRead  = !we0;
      MemoryWrite = we0;
      Address     = addr0;
      WriteData   = wdata0;
    end else if (pick1) begin
      MemoryRead  = !we1;
      MemoryWrite = we1;
      Address     = addr1;
      WriteData   = wdata1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      last     <= PORT_DMA;
      lock_act <= 1'b0;
      lock_cnt <= '0;
      rv0      <= 1'b0;
      rv1      <= 1'b0;
    end else begin
      if (pick0) begin
        last <= PORT_CPU;
      end else if (pick1) begin
        last <= PORT_DMA;
      end
      rv0      <= pick0 && !we0;
      rv1      <= pick1 && !we1;
      lock_act <= pick1 && lock1;
      // Count locked grants; holds at the cap so an uncontested lock keeps streaming.
      if (pick1 && lock1) begin
        if (!lock_act) begin
          lock_cnt <= 8'd1;
        end else if (lock_cnt < LOCK_CAP) begin
          lock_cnt <= lock_cnt + 8'd1;
        end
      end else begin
        lock_cnt <= '0;
      end
    end
  end

  assign rvalid0 = rv0;
  assign rvalid1 = rv1;
  assign rdata0  = rv0 ? ReadData : '0;
  assign rdata1  = rv1 ? ReadData : '0;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] conflict_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      conflict_q <= '0;
    end else if (req0 && req1 && (conflict_q != 32'hFFFF_FFFF)) begin
      conflict_q <= conflict_q + 32'd1;
    end
  end

  assign conflict_cnt = conflict_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter sharing the single-port 64x32 data memory between the CPU MEM stage (port 0) and the DMA/program-loader engine (port 1).
- Arbitrates every cycle, drives the memory's MemoryRead/MemoryWrite/Address/WriteData, and returns read data tagged to the winning requester one cycle later.
- Supports a bounded lock so port 1 can perform atomic read-modify-write sequences without starving the pipeline.

Parameters:
- ADDR_W, 6, memory address width (64 words)
- DATA_W, 32, data word width
- LOCK_MAX, 8, max consecutive cycles port 1 may retain the grant via lock1 (range 1..255)

Ports:
- Clock  in  1  system clock; all state updates on posedge
- Reset  in  1  asynchronous, active-high reset
- req0  in  1  port 0 request, held until gnt0
- we0  in  1  port 0 write (1) / read (0)
- addr0  in  ADDR_W  port 0 address
- wdata0  in  DATA_W  port 0 write data
- gnt0  out  1  port 0 access performed this cycle
- rvalid0  out  1  port 0 read data valid
- rdata0  out  DATA_W  port 0 read data
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1
- lock1  in  1  port 1 requests to keep the grant on following cycles
- MemoryRead  out  1  to memory read enable
- MemoryWrite  out  1  to memory write enable
- Address  out  ADDR_W  to memory address
- WriteData  out  DATA_W  to memory write data
- ReadData  in  DATA_W  from memory, valid the cycle after MemoryRead
- conflict_cnt  out  32  cycles with req0 && req1 (see Optional Feature)

Behaviour:
- Grant is combinational from the request lines and registered state. At most one of gnt0/gnt1 is high per cycle. gnt is never high without the matching req.
- Memory interface is combinational from the winner:
  - MemoryRead = gnt && !we
  - MemoryWrite = gnt && we
  - Address and WriteData come from the winner's addr/wdata.
  - With no grant: all four outputs are 0.
- Write completes on the falling edge of the grant cycle. A read is sampled by memory on the next posedge, so rvalidN goes high exactly 1 cycle after a read grant.
- rdataN = ReadData while rvalidN is high, else 0. rvalid is a registered tag; no buffering beyond one entry.
- Arbitration state:
  - last (1 bit): last granted port.
  - lock_act (1 bit).
  - lock_cnt (8 bits).
- Priority rules, evaluated each cycle in this order:
  1. If lock_act && req1 && lock1 && lock_cnt < LOCK_MAX, grant port 1.
  2. Otherwise, if only one port requests, grant it.
  3. Otherwise, if both request, grant the port != last (round-robin).
- On posedge with any grant, last <= granted port.
- lock_act <= gnt1 && lock1. lock_cnt increments while the lock is retained, reloads to 1 on the first locked grant, and clears when lock_act falls.
- Lock expiry: when lock_cnt reaches LOCK_MAX, rule 1 is skipped for that cycle. If req0 is high, port 0 wins (last=1). lock_act then clears, so port 1 must re-request.
- A lock with req0 low has no effect on port 0. Dropping req1 or lock1 ends the lock immediately.
- Same-address read and write in consecutive cycles behave as the memory dictates, with no forwarding. A write followed next cycle by a read of the same address returns the new data.
- Reset (async) forces:
  - last=1, so port 0 wins the first conflict
  - lock_act=0, lock_cnt=0
  - rvalid0=rvalid1=0
  - conflict_cnt=0
- Reset mid-read discards the pending rvalid. No grant is issued while Reset is high: all gnt and memory enables are 0.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- When defined: conflict_cnt increments every posedge where req0 && req1 and Reset is low. It saturates at 32'hFFFFFFFF.
- When undefined: the counter register is not built and conflict_cnt is tied to 0. The port list is unchanged.

Decomposition:
- Shared package holds:
  - ADDR_W/DATA_W defaults, matching the data memory
  - LOCK_MAX default
  - port index constants PORT_CPU=0, PORT_DMA=1
- One natural sub-module: dmem_rr_pick, the combinational two-way round-robin/lock priority picker (inputs req0, req1, last, lock_ok; outputs gnt0, gnt1). Registers and memory muxing stay in dmem_arbiter.

Test Plan:
- Reset release, then req0 read addr 5 (memory[5]=32'hDEAD0005) → gnt0 same cycle, MemoryRead=1, Address=5; rvalid0=1 with rdata0=32'hDEAD0005 next cycle; gnt1/rvalid1 stay 0.
- Both ports request for 4 cycles right after reset → grants alternate 0,1,0,1; conflict_cnt=4 with DMEM_ARB_PERF_EN defined, 0 without.
- Port 1 writes 32'h12345678 to addr 10, then port 0 reads addr 10 next cycle → MemoryWrite=1 in cycle 1; rdata0=32'h12345678 in cycle 3.
- LOCK_MAX=8, req1+lock1 held for 12 cycles with req0 high throughout → gnt1 for 8 consecutive cycles, then gnt0 for 1 cycle, then round-robin resumes.
- Reset asserted asynchronously mid-cycle right after a port 1 read grant → rvalid1 stays 0, all memory enables drop immediately; the first conflict after release goes to port 0.
- lock1 held with req0 low for 20 cycles → gnt1 every cycle with no forced release gap; lock_cnt saturates and never grants port 0 spuriously.
